// File: rtl/wide_word_uart_streamer.sv
// wide_word_uart_streamer: streams a wide word character by character into an 8N1 UART transmitter
module wide_word_uart_streamer #(
  parameter int WORD_BITS      = 512,
  parameter int MSB_FIRST      = 0,
  parameter int HEX_MODE       = 0,
  parameter int TRAILER_EN     = 0,
  parameter int TIMEOUT_CYCLES = 2600
) (
  input  logic                 hwclk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WORD_BITS-1:0] in_word,
  output logic                 in_ready,
  output logic [7:0]           tx_byte,
  output logic                 tx_send,
  output logic                 tx_en,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [15:0]          chars_sent
);
  localparam int NUM_BYTES = WORD_BITS / 8;
  localparam int BW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(NUM_BYTES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PRESENT, REQ, WAIT_END, ADV} state_t;

  state_t state, state_n;
  logic [WORD_BITS-1:0] shadow;
  logic [BW-1:0] byte_idx, k_idx;
  logic nib;
  logic [1:0] trail;
  logic [CW-1:0] cnt;
  logic sync1, tdn;
  logic [7:0] sel_byte, hex_char, char_n;
  logic [3:0] nibble;
  logic accept, timeout, last;

  assign accept   = in_valid & in_ready;
  assign timeout  = state == REQ && tdn && cnt == CNT_LAST;
  assign last     = trail == 2'd2 || (trail == 2'd0 && (HEX_MODE == 0 || nib) && byte_idx == LAST_IDX && TRAILER_EN == 0);
  assign k_idx    = MSB_FIRST != 0 ? LAST_IDX - byte_idx : byte_idx;
  assign sel_byte = shadow[{k_idx, 3'b000} +: 8];
  assign nibble   = nib ? sel_byte[3:0] : sel_byte[7:4];
  assign hex_char = nibble < 4'd10 ? 8'h30 + {4'h0, nibble} : 8'h37 + {4'h0, nibble};
  assign char_n   = trail == 2'd1 ? 8'h0D : trail == 2'd2 ? 8'h0A : HEX_MODE != 0 ? hex_char : sel_byte;
  assign in_ready = state == IDLE && !reset;
  assign tx_send  = state == REQ || state == WAIT_END;
  assign tx_en    = tx_send;
  assign busy     = state != IDLE;

  // bring the baud-domain done flag into hwclk; idle-high on reset
  always_ff @(posedge hwclk)
    if (reset) {sync1, tdn} <= 2'b11;
    else {sync1, tdn} <= {tx_done, sync1};

  // state register
  always_ff @(posedge hwclk)
    if (reset) state <= IDLE;
    else state <= state_n;

  // sequencing: an already-low tdn on entering REQ counts as the acknowledge
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = accept ? PRESENT : IDLE;
      PRESENT:  state_n = REQ;
      REQ:      state_n = !tdn ? WAIT_END : timeout ? IDLE : REQ;
      WAIT_END: state_n = tdn ? ADV : WAIT_END;
      ADV:      state_n = last ? IDLE : PRESENT;
      default:  state_n = IDLE;
    endcase
  end

  // word capture, character selection indices, timeout counter and counters
  always_ff @(posedge hwclk) begin
    if (reset) begin
      shadow      <= '0;
      byte_idx    <= '0;
      nib         <= 1'b0;
      trail       <= 2'd0;
      cnt         <= '0;
      tx_byte     <= 8'h00;
      timeout_err <= 1'b0;
      chars_sent  <= 16'h0000;
    end else begin
      timeout_err <= timeout;
      cnt         <= state == REQ ? cnt + 1'b1 : '0;
      if (accept) begin
        shadow   <= in_word;
        byte_idx <= '0;
        nib      <= 1'b0;
        trail    <= 2'd0;
      end
      if (state == PRESENT) tx_byte <= char_n;
      if (state == WAIT_END && tdn) chars_sent <= chars_sent + 1'b1;
      if (state == ADV && !last) begin
        if (trail != 2'd0) trail <= 2'd2;
        else if (HEX_MODE != 0 && !nib) nib <= 1'b1;
        else begin
          nib <= 1'b0;
          if (byte_idx == LAST_IDX) trail <= 2'd1;
          else byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wide_word_uart_streamer.sv
// tb_wide_word_uart_streamer: random words through four configurations against a character-list model
module tb_wide_word_uart_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string hx = "0123456789ABCDEF";

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input int c, input string s);
    return $sformatf("c%0d_%s", c, s);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int WB  = g == 2 ? 512 : g == 3 ? 8 : 32;
    localparam int MSB = g == 1 ? 1 : 0;
    localparam int HEX = (g == 1 || g == 3) ? 1 : 0;
    localparam int TR  = HEX;
    localparam int TO  = g == 3 ? 16 : 2600;
    localparam int NB  = WB / 8;
    localparam int CH  = NB * (HEX != 0 ? 2 : 1) + (TR != 0 ? 2 : 0);
    localparam int NW  = g == 2 ? 2 : g == 3 ? 4 : 6;
    localparam int ACK = 5;
    localparam int FIN = 20;
    localparam int BND = 40 * CH + 100;

    logic rst = 1'b1, valid = 1'b0, ready, send, en, busy, terr;
    logic tdone = 1'b1, never = 1'b0, done = 1'b0;
    logic active = 1'b0, prev = 1'b0;
    logic [WB-1:0] word = '0;
    logic [7:0] tx_byte;
    logic [15:0] chars, exp_tot = 16'h0;
    logic [7:0] exp_q[$];
    int nstart = 0, t = 0;

    wide_word_uart_streamer #(
      .WORD_BITS(WB), .MSB_FIRST(MSB), .HEX_MODE(HEX), .TRAILER_EN(TR), .TIMEOUT_CYCLES(TO)
    ) dut (
      .hwclk(clk), .reset(rst), .in_valid(valid), .in_word(word), .in_ready(ready),
      .tx_byte(tx_byte), .tx_send(send), .tx_en(en), .tx_done(tdone), .busy(busy),
      .timeout_err(terr), .chars_sent(chars)
    );

    // transmitter: drops done ACK cycles after a send rise, raises it again at FIN
    always @(negedge clk) begin
      if (rst) begin
        tdone  <= 1'b1;
        active <= 1'b0;
        prev   <= 1'b0;
      end else begin
        prev <= send;
        if (send && !prev) begin
          nstart <= nstart + 1;
          if (!never) begin
            active <= 1'b1;
            t <= 0;
            if (exp_q.size() == 0) check(tg(g, "extra_char"), tx_byte, 8'hFF ^ tx_byte);
            else check($sformatf("c%0d_char%0d", g, nstart), tx_byte, exp_q.pop_front());
          end
        end else if (active) begin
          t <= t + 1;
          if (t + 1 == ACK) tdone <= 1'b0;
          if (t + 1 == FIN) begin
            tdone  <= 1'b1;
            active <= 1'b0;
          end
        end
      end
    end

    always @(negedge clk)
      if (!rst) begin
        check(tg(g, "en_eq_send"), en, send);
        if (busy) check(tg(g, "ready_while_busy"), ready, 1'b0);
      end

    initial begin
      logic [WB-1:0] w;
      logic [7:0] b;
      int n, hi, base;
      bit gap;
      repeat (3) @(negedge clk);
      check(tg(g, "rst_ready"), ready, 1'b0);
      check(tg(g, "rst_send"), send, 1'b0);
      check(tg(g, "rst_busy"), busy, 1'b0);
      check(tg(g, "rst_terr"), terr, 1'b0);
      check(tg(g, "rst_chars"), chars, 16'h0);
      check(tg(g, "rst_byte"), tx_byte, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      check(tg(g, "idle_ready"), ready, 1'b1);
      for (int k = 0; k < NW; k++) begin
        if (g == 3 && k == 1) begin
          never = 1'b1;
          valid = 1'b1;
          word = WB'($urandom);
          check(tg(g, "to_accept"), ready, 1'b1);
          @(posedge clk);
          #1;
          @(negedge clk);
          valid = 1'b0;
          n = 0;
          while (!send && n < 20) begin
            @(negedge clk);
            n++;
          end
          hi = 0;
          while (send && hi < 100) begin
            hi++;
            @(negedge clk);
          end
          check(tg(g, "to_req_cycles"), hi, TO);
          check(tg(g, "to_pulse"), terr, 1'b1);
          check(tg(g, "to_send"), send, 1'b0);
          check(tg(g, "to_busy"), busy, 1'b0);
          check(tg(g, "to_ready"), ready, 1'b1);
          check(tg(g, "to_chars"), chars, exp_tot);
          @(negedge clk);
          check(tg(g, "to_pulse_end"), terr, 1'b0);
          never = 1'b0;
        end
        for (int i = 0; i < NB; i++)
          w[8*i +: 8] = k > 0 ? 8'($urandom) : (g == 0 || g == 1) ? 8'(32'hA1B2C3D4 >> (8 * i)) :
                        g == 2 ? 8'(i) : 8'h5E;
        valid = 1'b1;
        word = w;
        n = 0;
        while (!ready && n < BND) begin
          @(negedge clk);
          n++;
        end
        check(tg(g, "accept"), ready, 1'b1);
        if (!ready) break;
        @(posedge clk);
        #1;
        for (int i = 0; i < NB; i++) begin
          b = MSB != 0 ? w[8*(NB-1-i) +: 8] : w[8*i +: 8];
          if (HEX != 0) begin
            exp_q.push_back(hx[b[7:4]]);
            exp_q.push_back(hx[b[3:0]]);
          end else exp_q.push_back(b);
        end
        if (TR != 0) begin
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
        end
        exp_tot += 16'(CH);
        @(negedge clk);
        if (g == 0 && k == 2) begin
          valid = 1'b0;
          base = nstart;
          n = 0;
          while (nstart < base + 3 && n < 300) begin
            @(negedge clk);
            n++;
          end
          repeat (10) @(negedge clk);
          check(tg(g, "mid_send"), send, 1'b1);
          check(tg(g, "mid_chars"), chars, exp_tot - 16'(CH) + 16'd2);
          rst = 1'b1;
          @(negedge clk);
          check(tg(g, "mid_rst_send"), send, 1'b0);
          check(tg(g, "mid_rst_busy"), busy, 1'b0);
          check(tg(g, "mid_rst_chars"), chars, 16'h0);
          check(tg(g, "mid_rst_ready"), ready, 1'b0);
          exp_q.delete();
          exp_tot = 16'h0;
          @(negedge clk);
          rst = 1'b0;
          @(negedge clk);
          check(tg(g, "mid_rst_idle"), ready, 1'b1);
          continue;
        end
        gap = g == 3 || k % 2 == 1 || k == NW - 1;
        if (gap) begin
          valid = 1'b0;
          n = 0;
          while (busy && n < BND) begin
            @(negedge clk);
            n++;
          end
          check(tg(g, "end_busy"), busy, 1'b0);
          check(tg(g, "end_ready"), ready, 1'b1);
          check(tg(g, "end_chars"), chars, exp_tot);
          check(tg(g, "end_queue"), exp_q.size(), 0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check("all_done", n < 60000, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wide_word_uart_streamer.md
Name: wide_word_uart_streamer

Overview:
- Accepts a parametrised-width data word, e.g. a 512-bit cipher keystream block, through a valid/ready handshake.
- Streams the word one character at a time into the existing 8N1 UART transmitter via its send/done handshake.
- Generalises the fixed byte-dump sequencer with:
  - configurable width and byte order;
  - optional ASCII-hex encoding;
  - optional CR/LF trailer;
  - a start-acknowledge timeout.
- Sits between the keystream generator and uart_tx_8n1 in the top level.

Parameters:
- WORD_BITS, 512, input word width; multiple of 8, minimum 8; NUM_BYTES = WORD_BITS/8.
- MSB_FIRST, 0, 0 = byte 0 (bits 7:0) sent first; 1 = top byte sent first.
- HEX_MODE, 0, 1 = each byte sent as two uppercase ASCII hex characters, high nibble first.
- TRAILER_EN, 0, 1 = append 0x0D then 0x0A after the last character of each word.
- TIMEOUT_CYCLES, 2600, hwclk cycles allowed for tx_done to fall after tx_send rises; counter width clog2(TIMEOUT_CYCLES+1).

Ports:
- hwclk  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  word offered.
- in_word  in  WORD_BITS  word to stream.
- in_ready  out  1  block can accept a word.
- tx_byte  out  8  character presented to the transmitter.
- tx_send  out  1  transmit request, level-held.
- tx_en  out  1  transmitter enable; equals tx_send.
- tx_done  in  1  transmitter idle/finished, high when idle; asynchronous to hwclk (baud domain).
- busy  out  1  high from word accept until the last character completes.
- timeout_err  out  1  one-cycle pulse on a start-acknowledge timeout.
- chars_sent  out  16  count of completed characters since reset; wraps at 0xFFFF.

Behaviour:
- Reset values: in_ready=0 during reset, 1 in the first IDLE cycle after; tx_byte=0, tx_send=0, tx_en=0, busy=0, timeout_err=0, chars_sent=0; state=IDLE; shadow register and indices cleared.
- tx_done synchronisation: passed through a 2-flop synchroniser; all decisions use the synchronised value tdn.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_word into the shadow register, set byte_idx=0, nib=0, trail=0, busy=1, go to PRESENT.
  - The input word is never sampled again until IDLE.
- PRESENT (1 cycle):
  - in_ready=0; drive tx_byte from the current selection.
  - Selected byte = shadow[8*k+7:8*k], where k=byte_idx if MSB_FIRST=0, else NUM_BYTES-1-byte_idx.
  - HEX_MODE: nibble n maps to 0x30+n for n<10, 0x37+n for n≥10; nib=0 selects the high nibble.
  - Trailer phase: trail=1 → 0x0D, trail=2 → 0x0A.
  - Go to REQ.
- REQ:
  - tx_send=1, tx_en=1; timeout counter counts up from 0.
  - tdn==0 → WAIT_END, counter cleared.
  - Counter reaching TIMEOUT_CYCLES with tdn still 1 → tx_send=0, one-cycle timeout_err, word discarded, busy=0, state=IDLE.
- WAIT_END:
  - Hold tx_send until tdn==1.
  - Then: tx_send=0, tx_en=0, chars_sent+1, go to ADV.
  - No timeout in this state.
- ADV (tx_send low here; guarantees ≥1 low cycle between characters):
  - Advance nib (HEX_MODE), then byte_idx, then trail.
  - Last character of the word, or of the trailer when TRAILER_EN=1 → busy=0, IDLE.
  - Otherwise → PRESENT.
- Characters per word: NUM_BYTES × (HEX_MODE?2:1) + (TRAILER_EN?2:0).
- Boundaries:
  - in_valid held high continuously → next word accepted in the cycle after returning to IDLE; words are never overlapped.
  - WORD_BITS=8 → single byte, byte_idx never wraps.
  - tdn already 0 on entering REQ (transmitter still busy from outside) → treated as acknowledge. This is accepted behaviour; the top level guarantees exclusive use of the transmitter.
  - reset mid-word → everything returns to reset values next cycle and tx_send drops immediately; the partially sent character is not counted.

Test Plan:
1. WORD_BITS=32, MSB_FIRST=0, in_word=0xA1B2C3D4, transmitter model acks after 5 cycles and finishes after 20 → bytes D4,C3,B2,A1 in order; chars_sent=4; busy falls after the 4th tdn rise; in_ready=1 the next cycle.
2. Same word with MSB_FIRST=1, HEX_MODE=1, TRAILER_EN=1 → characters 'A','1','B','2','C','3','D','4',0x0D,0x0A; chars_sent=10.
3. WORD_BITS=512 with keystream pattern bytes 0x00..0x3F → 64 characters in index order; tx_send low for ≥1 cycle between each pair.
4. Transmitter model never drops tx_done, TIMEOUT_CYCLES=16 → timeout_err pulses exactly once at the 16th REQ cycle; tx_send=0, busy=0, chars_sent unchanged, in_ready=1 after.
5. Assert reset during the 3rd character's WAIT_END → next cycle tx_send=0, busy=0, chars_sent=0; a new word then streams correctly from byte 0.
6. in_valid held high with two back-to-back words → second word accepted only after the first word's final character; no interleaving; in_ready low throughout the first word.
